lopd_pipe_unit: RTL

//  Pipelined, parametrised leading-one position / leading-zero-count detector for FP normalisation.

---
 rtl/lopd_pkg.sv | 19 +
 rtl/lopd_chunk.sv | 22 ++
 rtl/lopd_pipe_unit.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/lopd_pkg.sv
// Shared types and width helpers for the pipelined leading-one / leading-zero detector.
package lopd_pkg;

  typedef enum logic {
    LOPD_MODE_POS = 1'b0,
    LOPD_MODE_LZC = 1'b1
  } lopd_mode_e;

  // Width of an index into an n-bit vector, never narrower than one bit.
  function automatic int unsigned lopd_idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold every value from 0 to n inclusive.
  function automatic int unsigned lopd_lop_w(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lopd_chunk.sv
// Combinational per-chunk detector: nonzero flag and index of the most significant one.
module lopd_chunk
  import lopd_pkg::*;
#(
  parameter int unsigned SIZE_CHUNK = 8,
  localparam int unsigned IDX_W     = lopd_idx_w(SIZE_CHUNK)
) (
  input  logic [SIZE_CHUNK-1:0] i_chunk,
  output logic                  o_nz,
  output logic [IDX_W-1:0]      o_idx
);

  always_comb begin
    o_nz  = |i_chunk;
    o_idx = '0;
    // Ascending scan: the last set bit seen is the most significant one.
    for (int unsigned i = 0; i < SIZE_CHUNK; i++) begin
      if (i_chunk[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lopd_pipe_unit.sv
// Two-stage leading-one position / leading-zero count unit with valid/ready flow control,
// tag passthrough, normalised-data output and synchronous flush.
module lopd_pipe_unit
  import lopd_pkg::*;
#(
  parameter int unsigned SIZE_DATA  = 32,
  parameter int unsigned SIZE_CHUNK = 8,
  parameter int unsigned SIZE_ADDR  = 32,
  localparam int unsigned SIZE_LOP  = lopd_lop_w(SIZE_DATA)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  lopd_mode_e           i_mode,
  input  logic [SIZE_ADDR-1:0] i_addr,
  input  logic [SIZE_DATA-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [SIZE_ADDR-1:0] o_addr,
  output logic [SIZE_LOP-1:0]  o_result,
  output logic                 o_zero_flag,
  output logic [SIZE_DATA-1:0] o_norm_data
);

  localparam int unsigned NUM_CHUNK = SIZE_DATA / SIZE_CHUNK;
  localparam int unsigned IDX_W     = lopd_idx_w(SIZE_CHUNK);

  // Stage-1 combinational chunk detection
  logic [NUM_CHUNK-1:0]            chunk_nz;
  logic [NUM_CHUNK-1:0][IDX_W-1:0] chunk_idx;

  for (genvar g = 0; g < NUM_CHUNK; g++) begin : g_chunk
    lopd_chunk #(
      .SIZE_CHUNK (SIZE_CHUNK)
    ) u_chunk (
      .i_chunk (i_data[g*SIZE_CHUNK +: SIZE_CHUNK]),
      .o_nz    (chunk_nz[g]),
      .o_idx   (chunk_idx[g])
    );
  end

  logic                            s1_valid_d, s1_valid_q;
  logic [NUM_CHUNK-1:0]            s1_nz_d, s1_nz_q;
  logic [NUM_CHUNK-1:0][IDX_W-1:0] s1_idx_d, s1_idx_q;
  lopd_mode_e                      s1_mode_d, s1_mode_q;
  logic [SIZE_ADDR-1:0]            s1_addr_d, s1_addr_q;
  logic [SIZE_DATA-1:0]            s1_data_d, s1_data_q;

  logic                 s2_valid_d, s2_valid_q;
  logic [SIZE_ADDR-1:0] addr_d, addr_q;
  logic [SIZE_LOP-1:0]  result_d, result_q;
  logic                 zero_d, zero_q;
  logic [SIZE_DATA-1:0] norm_d, norm_q;

  logic                en1, en2, accept;
  logic                s1_zero;
  logic [SIZE_LOP-1:0] lzc;

  // Flow control
  always_comb begin
    en2     = !s2_valid_q || i_ready;
    en1     = !s1_valid_q || en2;
    o_ready = en1 && !i_flush;
    accept  = i_valid && o_ready;
  end

  // Stage-2 combine: the highest nonzero chunk decides the leading-zero count
  always_comb begin
    s1_zero = ~|s1_nz_q;
    lzc     = SIZE_LOP'(SIZE_DATA);
    for (int unsigned c = 0; c < NUM_CHUNK; c++) begin
      if (s1_nz_q[c]) begin
        lzc = SIZE_LOP'((NUM_CHUNK - 1 - c) * SIZE_CHUNK
                        + (SIZE_CHUNK - 1 - 32'(s1_idx_q[c])));
      end
    end
  end

  // Next-state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_nz_d    = s1_nz_q;
    s1_idx_d   = s1_idx_q;
    s1_mode_d  = s1_mode_q;
    s1_addr_d  = s1_addr_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    addr_d     = addr_q;
    result_d   = result_q;
    zero_d     = zero_q;
    norm_d     = norm_q;

    if (en1) s1_valid_d = accept;
    if (en2) s2_valid_d = s1_valid_q;
    if (i_flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end

    if (accept) begin
      s1_nz_d   = chunk_nz;
      s1_idx_d  = chunk_idx;
      s1_mode_d = i_mode;
      s1_addr_d = i_addr;
      s1_data_d = i_data;
    end

    if (en2 && s1_valid_q) begin
      addr_d = s1_addr_q;
      zero_d = s1_zero;
      norm_d = s1_zero ? '0 : (s1_data_q << lzc);
      if (s1_mode_q == LOPD_MODE_LZC) begin
        result_d = lzc;
      end else begin
        result_d = s1_zero ? '0 : (SIZE_LOP'(SIZE_DATA - 1) - lzc);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_nz_q    <= '0;
      s1_idx_q   <= '0;
      s1_mode_q  <= LOPD_MODE_POS;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      addr_q     <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      norm_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_nz_q    <= s1_nz_d;
      s1_idx_q   <= s1_idx_d;
      s1_mode_q  <= s1_mode_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      addr_q     <= addr_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      norm_q     <= norm_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_addr      = addr_q;
  assign o_result    = result_q;
  assign o_zero_flag = zero_q;
  assign o_norm_data = norm_q;

endmodule
